// File: rtl/node_injector_if.sv
// Node-side handshake bundle for node_injector: packet descriptor stream plus body/tail payload stream.
interface node_injector_if #(
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int HPL_W = 12,
  parameter int BT_W  = 16,
  parameter int LEN_W = 4
);
  logic             pkt_valid_i;
  logic             pkt_ready_o;
  logic [X_W-1:0]   pkt_dest_x_i;
  logic [Y_W-1:0]   pkt_dest_y_i;
  logic [HPL_W-1:0] pkt_head_pl_i;
  logic [LEN_W-1:0] pkt_len_i;
  logic             pl_valid_i;
  logic             pl_ready_o;
  logic [BT_W-1:0]  pl_data_i;

  modport master (
    output pkt_valid_i, pkt_dest_x_i, pkt_dest_y_i, pkt_head_pl_i, pkt_len_i,
    output pl_valid_i, pl_data_i,
    input  pkt_ready_o, pl_ready_o
  );

  modport slave (
    input  pkt_valid_i, pkt_dest_x_i, pkt_dest_y_i, pkt_head_pl_i, pkt_len_i,
    input  pl_valid_i, pl_data_i,
    output pkt_ready_o, pl_ready_o
  );
endinterface

// File: rtl/node_injector.sv
// Mesh local-port injector: allocates a VC round-robin, segments a packet into flits under on/off flow control.
// Optional NODE_INJECTOR_STATS_EN adds pkt_count_o / flit_count_o injection counters.
package noc_params;
  localparam int VC_NUM            = 4;
  localparam int VC_SIZE           = $clog2(VC_NUM);
  localparam int DEST_ADDR_SIZE_X  = 2;
  localparam int DEST_ADDR_SIZE_Y  = 2;
  localparam int HEAD_PAYLOAD_SIZE = 12;
  localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    union packed {
      head_data_t                head_data;
      logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } data;
  } flit_t;
endpackage

module node_injector
  import noc_params::*;
#(
  parameter int MAX_PKT_FLITS = 8,
  parameter int LEN_W         = $clog2(MAX_PKT_FLITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  node_injector_if.slave     nif,
  output flit_t              data_o,
  output logic               is_valid_o,
  input  logic [VC_NUM-1:0]  is_on_off_i,
  input  logic [VC_NUM-1:0]  is_allocatable_i
`ifdef NODE_INJECTOR_STATS_EN
  ,
  output logic [31:0]        pkt_count_o,
  output logic [31:0]        flit_count_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_SEND} state_t;

  state_t                        r_state;
  logic [VC_SIZE-1:0]            r_rr, r_vc;
  logic [LEN_W-1:0]              r_len, r_cnt;
  logic [DEST_ADDR_SIZE_X-1:0]   r_x;
  logic [DEST_ADDR_SIZE_Y-1:0]   r_y;
  logic [HEAD_PAYLOAD_SIZE-1:0]  r_hpl;

  logic [LEN_W-1:0]   w_len;
  logic               w_found;
  logic [VC_SIZE-1:0] w_cand, w_idx, w_rr_next;
  logic               w_head_fire, w_body_fire, w_tail, w_single;

  always_comb begin
    w_len = nif.pkt_len_i;
    if (nif.pkt_len_i == '0)
      w_len = LEN_W'(1);
    else if (nif.pkt_len_i > LEN_W'(MAX_PKT_FLITS))
      w_len = LEN_W'(MAX_PKT_FLITS);
  end

  // First allocatable VC scanning upward from the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    w_idx   = '0;
    for (int k = 0; k < VC_NUM; k++) begin
      w_idx = VC_SIZE'((int'(r_rr) + k) % VC_NUM);
      if (!w_found && is_allocatable_i[w_idx]) begin
        w_found = 1'b1;
        w_cand  = w_idx;
      end
    end
  end

  assign w_rr_next   = (w_cand == VC_SIZE'(VC_NUM - 1)) ? '0 : w_cand + 1'b1;
  assign w_single    = (r_len == LEN_W'(1));
  assign w_tail      = (r_cnt == r_len - 1'b1);
  assign w_head_fire = (r_state == S_ALLOC) && w_found && is_on_off_i[w_cand];
  assign w_body_fire = (r_state == S_SEND) && nif.pl_valid_i && is_on_off_i[r_vc];

  assign nif.pkt_ready_o = (r_state == S_IDLE);
  assign nif.pl_ready_o  = (r_state == S_SEND) && is_on_off_i[r_vc];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr       <= '0;
      r_vc       <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_hpl      <= '0;
      data_o     <= '0;
      is_valid_o <= 1'b0;
    end else begin
      is_valid_o <= 1'b0;
      case (r_state)
        S_IDLE: if (nif.pkt_valid_i) begin
          r_x     <= nif.pkt_dest_x_i;
          r_y     <= nif.pkt_dest_y_i;
          r_hpl   <= nif.pkt_head_pl_i;
          r_len   <= w_len;
          r_state <= S_ALLOC;
        end
        S_ALLOC: if (w_head_fire) begin
          data_o.flit_label             <= w_single ? HEADTAIL : HEAD;
          data_o.vc_id                  <= w_cand;
          data_o.data.head_data.x_dest  <= r_x;
          data_o.data.head_data.y_dest  <= r_y;
          data_o.data.head_data.head_pl <= r_hpl;
          is_valid_o <= 1'b1;
          r_vc       <= w_cand;
          r_rr       <= w_rr_next;
          r_cnt      <= LEN_W'(1);
          r_state    <= w_single ? S_IDLE : S_SEND;
        end
        S_SEND: if (w_body_fire) begin
          data_o.flit_label <= w_tail ? TAIL : BODY;
          data_o.vc_id      <= r_vc;
          data_o.data.bt_pl <= nif.pl_data_i;
          is_valid_o <= 1'b1;
          r_cnt      <= r_cnt + 1'b1;
          if (w_tail) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef NODE_INJECTOR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count_o  <= '0;
      flit_count_o <= '0;
    end else begin
      if (w_head_fire || w_body_fire)
        flit_count_o <= flit_count_o + 32'd1;
      if ((w_head_fire && w_single) || (w_body_fire && w_tail))
        pkt_count_o <= pkt_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_node_injector.sv
// Directed bench for node_injector: vector table of packets plus hand sequences for stall, allocation wait and reset.
module tb_node_injector;
  import noc_params::*;

  localparam int MAXF = 8;
  localparam int LW   = $clog2(MAXF + 1);

  logic              clk = 1'b0;
  logic              rst;
  flit_t             data_o;
  logic              is_valid_o;
  logic [VC_NUM-1:0] on_off, alloc;
  logic [15:0]       pl_word = 16'h1000;
  int                checks = 0, errors = 0;

  node_injector_if #(.X_W(DEST_ADDR_SIZE_X), .Y_W(DEST_ADDR_SIZE_Y), .HPL_W(HEAD_PAYLOAD_SIZE),
                     .BT_W(FLIT_DATA_SIZE), .LEN_W(LW)) nif ();

`ifdef NODE_INJECTOR_STATS_EN
  logic [31:0] pkt_count_o, flit_count_o;
`endif

  node_injector #(.MAX_PKT_FLITS(MAXF)) dut (
    .clk(clk), .rst(rst), .nif(nif), .data_o(data_o), .is_valid_o(is_valid_o),
    .is_on_off_i(on_off), .is_allocatable_i(alloc)
`ifdef NODE_INJECTOR_STATS_EN
    , .pkt_count_o(pkt_count_o), .flit_count_o(flit_count_o)
`endif
  );

  always #5 clk = ~clk;
  assign nif.pl_data_i = pl_word;

  // Payload source: advance to the next word only after one was consumed.
  always begin : feeder
    logic take;
    @(negedge clk);
    take = nif.pl_valid_i && nif.pl_ready_o;
    @(posedge clk);
    if (take && !rst) begin
      #2;
      pl_word = pl_word + 16'd1;
    end
  end

`ifdef NODE_INJECTOR_STATS_EN
  int mon_f = 0, mon_p = 0;
  always begin : monitor
    @(posedge clk or posedge rst);
    if (rst) begin
      mon_f = 0; mon_p = 0;
    end else begin
      #1;
      if (is_valid_o) begin
        mon_f++;
        if (data_o.flit_label inside {TAIL, HEADTAIL}) mon_p++;
      end
    end
  end
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] x, input logic [1:0] y, input logic [11:0] hpl,
                       input logic [LW-1:0] len);
    int w = 0;
    nif.pkt_dest_x_i  = x;
    nif.pkt_dest_y_i  = y;
    nif.pkt_head_pl_i = hpl;
    nif.pkt_len_i     = len;
    nif.pkt_valid_i   = 1'b1;
    @(negedge clk);
    while (!nif.pkt_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!nif.pkt_ready_o) chk("accept_timeout", 64'(nif.pkt_ready_o), 64'd1);
    @(posedge clk);
    #1 nif.pkt_valid_i = 1'b0;
  endtask

  task automatic wait_flit(input int limit, output flit_t f, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!is_valid_o && lat < limit);
    if (!is_valid_o) chk("flit_timeout", 64'(is_valid_o), 64'd1);
    f = data_o;
  endtask

  typedef struct {
    logic [1:0]  x, y;
    logic [11:0] hpl;
    logic [3:0]  len;
    logic [3:0]  alloc;
    int          vc;
    int          n;
  } vec_t;

  task automatic run_vec(input vec_t v);
    flit_t       f;
    int          lat;
    logic [15:0] w0 = pl_word;
    alloc = v.alloc;
    issue(v.x, v.y, v.hpl, LW'(v.len));
    wait_flit(20, f, lat);
    chk("head_latency", 64'(lat), 64'd1);
    chk("head_label", 64'(f.flit_label), 64'(v.n == 1 ? HEADTAIL : HEAD));
    chk("head_vc", 64'(f.vc_id), 64'(v.vc));
    chk("head_dest", 64'({f.data.head_data.x_dest, f.data.head_data.y_dest}), 64'({v.x, v.y}));
    chk("head_pl", 64'(f.data.head_data.head_pl), 64'(v.hpl));
    for (int k = 1; k < v.n; k++) begin
      @(posedge clk);
      #1;
      chk("bt_valid", 64'(is_valid_o), 64'd1);
      chk("bt_label", 64'(data_o.flit_label), 64'(k == v.n - 1 ? TAIL : BODY));
      chk("bt_vc", 64'(data_o.vc_id), 64'(v.vc));
      chk("bt_pl", 64'(data_o.data.bt_pl), 64'(w0 + 16'(k - 1)));
    end
    @(posedge clk);
    #1;
    chk("post_pkt_idle", 64'(is_valid_o), 64'd0);
    chk("words_used", 64'(pl_word), 64'(w0 + 16'(v.n - 1)));
    chk("post_pkt_ready", 64'(nif.pkt_ready_o), 64'd1);
  endtask

  vec_t tbl[11];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    flit_t       f;
    int          lat;
    logic [15:0] w0;

    tbl[0]  = '{2'd1, 2'd2, 12'h0AB, 4'd0,  4'hF, 1, 1};
    tbl[1]  = '{2'd3, 2'd0, 12'hFFF, 4'd0,  4'hF, 2, 1};
    tbl[2]  = '{2'd0, 2'd1, 12'h123, 4'd0,  4'hF, 3, 1};
    tbl[3]  = '{2'd2, 2'd2, 12'h456, 4'd0,  4'hF, 0, 1};
    tbl[4]  = '{2'd1, 2'd1, 12'h0A0, 4'd4,  4'hF, 1, 4};
    tbl[5]  = '{2'd3, 2'd3, 12'h777, 4'd1,  4'h1, 0, 1};
    tbl[6]  = '{2'd0, 2'd3, 12'h800, 4'd15, 4'h8, 3, 8};
    tbl[7]  = '{2'd2, 2'd1, 12'h321, 4'd8,  4'h6, 1, 8};
    tbl[8]  = '{2'd1, 2'd0, 12'h00F, 4'd2,  4'h4, 2, 2};
    tbl[9]  = '{2'd0, 2'd0, 12'hABC, 4'd1,  4'hF, 3, 1};
    tbl[10] = '{2'd3, 2'd1, 12'h5A5, 4'd9,  4'hF, 0, 8};

    nif.pkt_valid_i = 1'b0; nif.pl_valid_i = 1'b0;
    nif.pkt_dest_x_i = '0; nif.pkt_dest_y_i = '0; nif.pkt_head_pl_i = '0; nif.pkt_len_i = '0;
    on_off = '1; alloc = '1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_pkt_ready", 64'(nif.pkt_ready_o), 64'd1);
    chk("rst_pl_ready", 64'(nif.pl_ready_o), 64'd0);
    chk("rst_valid", 64'(is_valid_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    nif.pl_valid_i = 1'b1;

    // Single-flit packet: HEADTAIL on VC0, no payload consumed.
    w0 = pl_word;
    issue(2'd2, 2'd3, 12'h005, LW'(1));
    wait_flit(20, f, lat);
    chk("single_latency", 64'(lat), 64'd1);
    chk("single_label", 64'(f.flit_label), 64'(HEADTAIL));
    chk("single_vc", 64'(f.vc_id), 64'd0);
    chk("single_head", 64'(f.data.head_data), 64'({2'd2, 2'd3, 12'h005}));
    chk("single_ready_again", 64'(nif.pkt_ready_o), 64'd1);
    @(posedge clk);
    #1;
    chk("single_one_cycle", 64'(is_valid_o), 64'd0);
    chk("single_no_payload", 64'(pl_word), 64'(w0));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Flow-control stall on a len=3 packet; allocatable drops are ignored mid-packet.
    alloc = '1;
    w0 = pl_word;
    issue(2'd1, 2'd3, 12'h0CC, LW'(3));
    @(posedge clk);
    #1;
    chk("stall_head_valid", 64'(is_valid_o), 64'd1);
    chk("stall_head_label", 64'(data_o.flit_label), 64'(HEAD));
    chk("stall_head_vc", 64'(data_o.vc_id), 64'd1);
    on_off = 4'b1101;
    alloc  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pl_ready", 64'(nif.pl_ready_o), 64'd0);
      @(posedge clk);
      #1;
      chk("stall_no_flit", 64'(is_valid_o), 64'd0);
    end
    on_off = '1;
    @(posedge clk);
    #1;
    chk("stall_body", 64'({is_valid_o, data_o.flit_label, data_o.vc_id, data_o.data.bt_pl}),
        64'({1'b1, BODY, 2'd1, w0}));
    @(posedge clk);
    #1;
    chk("stall_tail", 64'({is_valid_o, data_o.flit_label, data_o.vc_id, data_o.data.bt_pl}),
        64'({1'b1, TAIL, 2'd1, w0 + 16'd1}));
    @(posedge clk);
    #1;
    chk("stall_done", 64'(is_valid_o), 64'd0);
    chk("stall_words", 64'(pl_word), 64'(w0 + 16'd2));

    // Allocation wait: nothing allocatable for 5 edges, then only VC1.
    alloc = '0;
    issue(2'd0, 2'd2, 12'h0EE, LW'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("alloc_wait_valid", 64'(is_valid_o), 64'd0);
      chk("alloc_wait_ready", 64'(nif.pkt_ready_o), 64'd0);
    end
    @(posedge clk);
    #1 alloc = 4'b0010;
    chk("alloc_still_none", 64'(is_valid_o), 64'd0);
    @(posedge clk);
    #1;
    chk("alloc_head", 64'({is_valid_o, data_o.flit_label, data_o.vc_id}), 64'({1'b1, HEADTAIL, 2'd1}));

    // Reset mid-packet after head and one body of a len=5 packet.
    alloc = '1;
    issue(2'd3, 2'd2, 12'h0DD, LW'(5));
    @(posedge clk);
    #1;
    chk("rmid_head_vc", 64'({is_valid_o, data_o.flit_label, data_o.vc_id}), 64'({1'b1, HEAD, 2'd2}));
    @(posedge clk);
    #1;
    chk("rmid_body", 64'(is_valid_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmid_valid", 64'(is_valid_o), 64'd0);
    chk("rmid_pkt_ready", 64'(nif.pkt_ready_o), 64'd1);
    chk("rmid_pl_ready", 64'(nif.pl_ready_o), 64'd0);
    chk("rmid_data", 64'(data_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_vec('{2'd1, 2'd1, 12'h111, 4'd1, 4'hF, 0, 1});

`ifdef NODE_INJECTOR_STATS_EN
    chk("stats_flits", 64'(flit_count_o), 64'(mon_f));
    chk("stats_pkts", 64'(pkt_count_o), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/node_injector.md
Name: node_injector

Overview:
- Network-interface stage that feeds the mesh local port (data_i / is_valid_i, with is_on_off_o / is_allocatable_o returned) of one router.
- Accepts a packet descriptor plus a payload word stream from a node, allocates a downstream virtual channel, segments the packet into HEAD/BODY/TAIL (or HEADTAIL) flit_t flits, and injects them under per-VC on/off flow control.
- Uses flit_t and VC_NUM from noc_params. flit_t fields: flit_label, vc_id, head_data {x_dest, y_dest, head_pl}, bt_pl.

Parameters:
- MAX_PKT_FLITS, 8, maximum flits per packet including head; a legal packet is 1..MAX_PKT_FLITS flits.
- LEN_W, $clog2(MAX_PKT_FLITS+1), width of pkt_len_i.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- pkt_valid_i  input  1  descriptor valid.
- pkt_ready_o  output  1  descriptor accepted when valid & ready.
- pkt_dest_x_i  input  width of flit x_dest  destination column.
- pkt_dest_y_i  input  width of flit y_dest  destination row.
- pkt_head_pl_i  input  width of head_pl  head payload.
- pkt_len_i  input  LEN_W  total flit count.
- pl_valid_i  input  1  body/tail payload word valid.
- pl_ready_o  output  1  payload word consumed when valid & ready.
- pl_data_i  input  width of bt_pl  body/tail payload.
- data_o  output  flit_t  flit to the router local port.
- is_valid_o  output  1  data_o valid this cycle.
- is_on_off_i  input  VC_NUM  per-VC "may send one flit".
- is_allocatable_i  input  VC_NUM  per-VC "free for a new packet".

Behaviour:
- **Reset** (async, immediate): state=IDLE; pkt_ready_o=1, pl_ready_o=0, is_valid_o=0, data_o=0, rr_ptr=0, flit counter=0. A partial packet in flight is dropped; the router is reset by the same rst.
- **Output register:** data_o and is_valid_o are registered. is_valid_o is high for exactly one cycle per flit injected.
- **IDLE:** pkt_ready_o=1. On accept, latch dest, head_pl and len, then go to ALLOC.
  - Length clamp: len=0 is treated as 1; len>MAX_PKT_FLITS is clamped to MAX_PKT_FLITS.
- **ALLOC:** pkt_ready_o=0, pl_ready_o=0.
  - Candidate VC: the first VC at or after rr_ptr (wrapping at VC_NUM) with is_allocatable_i=1.
  - If a candidate exists and its is_on_off_i=1, register the head flit: vc_id=candidate, dest, head_pl, label HEAD (HEADTAIL if len=1).
  - On that same edge: latch the VC, set rr_ptr=(candidate+1) mod VC_NUM, and set count=1.
  - Next state is IDLE if len=1, otherwise SEND.
  - Otherwise stay in ALLOC with no flit and no pointer change.
- **SEND:** pl_ready_o = is_on_off_i[vc].
  - On pl_valid_i & pl_ready_o, register a flit on the latched VC with bt_pl=pl_data_i, and increment count.
  - Label is TAIL when count==len-1, else BODY. After TAIL, go to IDLE.
  - If on_off is low or pl_valid_i is low, no flit is sent and nothing advances. Gaps between flits are legal.
- **Latency:** descriptor accepted at edge E0. With a VC free and on, the head is visible in the cycle after E1; back-to-back body flits follow at one per cycle.
- **Packet-to-packet gap:** after a tail or headtail, IDLE lasts at least one cycle, so the router can deassert is_allocatable for the used VC before the next ALLOC samples it.
- **Wrap-around:** rr_ptr at VC_NUM-1 wraps to 0.
- **Simultaneous events:** is_allocatable_i changes during SEND are ignored; the VC is held until the tail is sent.
- **Payload outside SEND:** payload words are never consumed outside SEND.

Optional Feature:
- Macro: NODE_INJECTOR_STATS_EN.
- Defined: adds outputs pkt_count_o[31:0] and flit_count_o[31:0].
  - pkt_count_o increments on each tail/headtail injected; flit_count_o increments on each flit injected.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- **Single-flit packet:** len=1, dest (2,3), head_pl=0x5, all VCs allocatable and on -> one HEADTAIL on vc_id 0 in the cycle after E1; then pkt_ready_o=1 again; rr_ptr=1.
- **Multi-flit packet:** len=4 with payload words A,B,C presented continuously -> HEAD, BODY(A), BODY(B), TAIL(C) on consecutive cycles; is_valid_o high for 4 cycles.
- **Flow control stall:** during a len=3 packet, is_on_off_i[vc]=0 for 3 cycles after the head -> pl_ready_o=0 and is_valid_o=0 for those cycles; resumes with BODY then TAIL; no payload is lost.
- **Allocation:** is_allocatable_i=0 for all VCs for 5 cycles, then only VC 1 -> stays in ALLOC for 5 cycles, then the head goes out on vc_id 1.
- **Round-robin and length clamp:** four successive len=0 packets with all VCs free -> four HEADTAILs on vc_id 0,1,…,VC_NUM-1, wrapping back to 0.
- **Reset mid-packet:** assert rst asynchronously after the head of a len=5 packet -> is_valid_o=0 immediately, state IDLE, pkt_ready_o=1; the next packet starts on vc_id 0.
